// File: rtl/store_rmw_ctrl.sv
// Purpose: sub-word store controller; word stores write directly, byte/halfword stores read-merge-write.
// Latency: word store writes 1 cycle after acceptance, partial store writes 3 cycles after acceptance.
// Backpressure: req_ready only in IDLE; busy stalls the pipeline for the whole store.
// Option: define MISALIGN_EXC_EN to flag misaligned stores (pulse misalign, drop the store)
//         instead of silently aligning them.
module store_rmw_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic [31:0]       req_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        merge_mask,
  output logic [31:0]       merge_wdata,
  output logic [31:0]       merge_old,
  input  logic [31:0]       merge_new,
  output logic              busy,
  output logic              misalign
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    CAPT  = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        mask_q, mask_d;
  logic [31:0]       data_q, data_d;
  logic [31:0]       wdata_q, wdata_d;

  // Request decode: byte-lane mask and store data moved into its byte lanes.
  logic [3:0]  req_mask;
  logic [31:0] req_lane;
`ifdef MISALIGN_EXC_EN
  logic        req_misal;
  logic        misalign_q, misalign_d;
`endif

  // Decode size/offset of the incoming request into lane mask and lane-aligned data.
  always_comb begin
    req_mask = 4'b1111;
    req_lane = req_data;
`ifdef MISALIGN_EXC_EN
    req_misal = 1'b0;
`endif
    case (req_size)
      2'b00: begin
        req_mask = 4'b0001 << req_addr[1:0];
        req_lane = {24'h0, req_data[7:0]} << {req_addr[1:0], 3'b000};
      end
      2'b01: begin
        // Halfword lane chosen by addr[1]; addr[0] never moves the data.
        req_mask = req_addr[1] ? 4'b1100 : 4'b0011;
        req_lane = req_addr[1] ? {req_data[15:0], 16'h0} : {16'h0, req_data[15:0]};
`ifdef MISALIGN_EXC_EN
        req_misal = req_addr[0];
`endif
      end
      default: begin
        // 2'b10 word and reserved 2'b11 both behave as a word store.
        req_mask = 4'b1111;
        req_lane = req_data;
`ifdef MISALIGN_EXC_EN
        req_misal = (req_addr[1:0] != 2'b00);
`endif
      end
    endcase
  end

  // Next-state logic: accept in IDLE, then either write directly or read-capture-write.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    mask_d  = mask_q;
    data_d  = data_q;
    wdata_d = wdata_q;
`ifdef MISALIGN_EXC_EN
    misalign_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d = {req_addr[ADDR_W-1:2], 2'b00};
          mask_d = req_mask;
          data_d = req_lane;
`ifdef MISALIGN_EXC_EN
          if (req_misal) begin
            // Store is consumed but never reaches memory.
            misalign_d = 1'b1;
          end else
`endif
          if (req_mask == 4'b1111) begin
            wdata_d = req_data;
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: state_d = CAPT;
      CAPT: begin
        // Read data is on mem_rdata this cycle; keep the merged word for the write.
        wdata_d = merge_new;
        state_d = WRITE;
      end
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      mask_q  <= 4'b0000;
      data_q  <= 32'h0;
      wdata_q <= 32'h0;
`ifdef MISALIGN_EXC_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
      data_q  <= data_d;
      wdata_q <= wdata_d;
`ifdef MISALIGN_EXC_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign mem_re      = (state_q == READ);
  assign mem_we      = (state_q == WRITE);
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign merge_mask  = mask_q;
  assign merge_wdata = data_q;
  assign merge_old   = mem_rdata;
`ifdef MISALIGN_EXC_EN
  assign misalign    = misalign_q;
`else
  assign misalign    = 1'b0;
`endif

endmodule

// File: doc/store_rmw_ctrl.md
STORE_RMW_CTRL -- requirements
Module: store_rmw_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: byte-address width.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1: synchronous, active-low reset.
REQ-004 SHALL have port req_valid, input, 1: store request present.
REQ-005 SHALL have port req_ready, output, 1: request accepted on a cycle where req_valid and req_ready are both 1.
REQ-006 SHALL have port req_addr, input, ADDR_W: store byte address.
REQ-007 SHALL have port req_size, input, 2: 00 byte, 01 halfword, 10 word; 11 is reserved and treated as word.
REQ-008 SHALL have port req_data, input, 32: store data, right-justified (byte in [7:0], halfword in [15:0]).
REQ-009 SHALL have port mem_addr, output, ADDR_W: word-aligned address, low 2 bits 0.
REQ-010 SHALL have ports mem_re and mem_we, output, 1 each: read strobe and write strobe.
REQ-011 SHALL have port mem_rdata, input, 32: read data, valid exactly 1 cycle after mem_re.
REQ-012 SHALL have port mem_wdata, output, 32: write data.
REQ-013 SHALL have ports merge_mask (output, 4), merge_wdata (output, 32), merge_old (output, 32) and merge_new (input, 32): connection to the external combinational byte-merge unit.
REQ-014 SHALL have port busy, output, 1: stall to pipeline, 1 whenever state is not IDLE.
REQ-015 SHALL have port misalign, output, 1: one-cycle misaligned-store pulse.

Function
REQ-016 SHALL set mask to 1<<addr[1:0] for byte stores; 0011 for halfword stores with addr[1]=0, 1100 with addr[1]=1; 1111 for word stores. Mask bit3 is data[31:24].
REQ-017 SHALL latch addr, mask and data at acceptance and hold them stable on the merge_* ports until the next acceptance.
REQ-018 SHALL implement states IDLE, READ, CAPT and WRITE; req_ready=1 only in IDLE.
REQ-019 SHALL go IDLE->WRITE when a word store (mask 1111) is accepted at edge N; mem_we=1 during cycle N+1; no read is issued.
REQ-020 SHALL go IDLE->READ->CAPT->WRITE for a partial store accepted at edge N: mem_re=1 in N+1; in N+2 merge_old=mem_rdata and merge_new is registered; mem_we=1 with the registered merge_new in N+3.
REQ-021 SHALL go WRITE->IDLE unconditionally; a new request is accepted no earlier than the first IDLE cycle, giving back-to-back spacing of 2 cycles (word) or 4 cycles (partial).
REQ-022 SHALL drive mem_wdata=req_data in word-store WRITE, bypassing merge.
REQ-023 SHALL keep mem_re and mem_we mutually exclusive, each asserted for exactly one cycle per store.
REQ-024 SHALL hold mem_addr constant from READ through WRITE.
REQ-025 SHALL, when req_valid=0 in IDLE, stay in IDLE with no strobes.

Reset
REQ-026 SHALL, when rst_n=0 at a clock edge, enter IDLE with mem_re=0, mem_we=0, misalign=0, busy=0, mem_addr=0, mem_wdata=0 and merge_mask=0000.
REQ-027 SHALL, on reset during READ, CAPT or WRITE, abandon the store with no mem_we in the following cycle; reset has priority over acceptance.

Configuration
REQ-028 SHALL use macro MISALIGN_EXC_EN to select misaligned-store handling.
REQ-029 SHALL, with MISALIGN_EXC_EN defined, treat a halfword with addr[0]=1 or a word with addr[1:0]!=0 as follows: accept it, pulse misalign for 1 cycle after acceptance, issue no strobes and stay in IDLE.
REQ-030 SHALL, without MISALIGN_EXC_EN, tie misalign to 0, ignore offending low address bits (halfword uses addr[1], word uses 00), and process the store normally.

Verification
REQ-031 SHALL verify a word store: SW addr 0x10, data 0xDEADBEEF -> no mem_re; mem_we 1 cycle later with mem_addr 0x10 and wdata 0xDEADBEEF.
REQ-032 SHALL verify a byte store: SB addr 0x13, data 0x000000AA, old 0x11223344 -> mask 1000, mem_re at N+1, mem_we at N+3 with wdata 0xAA223344.
REQ-033 SHALL verify a halfword store: SH addr 0x22, data 0x0000BEEF, old 0x11223344 -> mask 1100, wdata 0xBEEF3344 at N+3.
REQ-034 SHALL verify back-to-back requests: SB then SW held valid -> second accepted on the first IDLE cycle, req_ready=0 for 3 cycles in between, both writes correct.
REQ-035 SHALL verify reset mid-store: rst_n=0 in CAPT -> no mem_we, IDLE next cycle, req_ready=1.
REQ-036 SHALL verify misalignment: SW addr 0x11 -> with MISALIGN_EXC_EN, misalign pulse and no strobes; without it, write to 0x10 and misalign stays 0.
